// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_sub.sv
// One-bit combinational full subtractor: d = a - b - br, bo = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ br;
  assign bo = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a start/busy/done handshake around a single full_sub cell.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CntW = (N > 1) ? $clog2(N) : 1;

  state_e            state_q, state_d;
  logic [N-1:0]      opA_q, opB_q, resultSh_q, diff_q;
  logic              br_q, bout_q, ovf_q;
  logic [CntW-1:0]   cnt_q;
  logic              bitD, bitBo;
  logic              accept, lastBit;

  full_sub u_cell (
    .a  (opA_q[0]),
    .b  (opB_q[0]),
    .br (br_q),
    .d  (bitD),
    .bo (bitBo)
  );

  assign accept  = start && (state_q == IDLE || state_q == DONE);
  assign lastBit = (state_q == RUN) && (cnt_q == CntW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The result builds in its own shift register so that diff only moves on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q      <= '0;
      opB_q      <= '0;
      resultSh_q <= '0;
      diff_q     <= '0;
      br_q       <= 1'b0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      opA_q <= a;
      opB_q <= b;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      opA_q      <= {1'b0, opA_q[N-1:1]};
      opB_q      <= {1'b0, opB_q[N-1:1]};
      resultSh_q <= {bitD, resultSh_q[N-1:1]};
      br_q       <= bitBo;
      cnt_q      <= cnt_q + CntW'(1);
      if (lastBit) begin
        diff_q <= {bitD, resultSh_q[N-1:1]};
        bout_q <= bitBo;
        ovf_q  <= br_q ^ bitBo;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed table, handshake corner cases, random sweep.
module tb_serial_sub;

  localparam int N       = 8;
  localparam int MaxWait = 40;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] aIn   = '0;
  logic [N-1:0] bIn   = '0;
  logic         binIn = 1'b0;
  logic         busy, done, bout, ovf;
  logic [N-1:0] diff;

  int total = 0;
  int bad   = 0;
  int overlapCount = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] expDiff;
    logic         expBout;
    logic         expOvf;
  } vec_t;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  vec_t vecs[10];

  serial_sub #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (aIn),
    .b     (bIn),
    .bin   (binIn),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlapCount++;

  function automatic res_t refSub(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    res_t r;
    logic [N:0] wide;
    int sa, sb, s;
    wide   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
    r.diff = wide[N-1:0];
    r.bout = wide[N];
    sa = $signed(a);
    sb = $signed(b);
    s  = sa - sb - int'(bi);
    r.ovf  = (s > (2 ** (N - 1)) - 1) || (s < -(2 ** (N - 1)));
    return r;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                               output int lat);
    aIn   = a;
    bIn   = b;
    binIn = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < MaxWait) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] expDiff,
                             input logic expBout, input logic expOvf, input int lat);
    compare({name, ".done"},    32'(done), 32'd1);
    compare({name, ".latency"}, 32'(lat),  32'(N + 1));
    compare({name, ".diff"},    32'(diff), 32'(expDiff));
    compare({name, ".bout"},    32'(bout), 32'(expBout));
    compare({name, ".ovf"},     32'(ovf),  32'(expOvf));
    @(negedge clk);
    compare({name, ".donePulse"}, 32'(done), 32'd0);
    compare({name, ".diffHeld"},  32'(diff), 32'(expDiff));
  endtask

  initial begin
    int   lat;
    int   doneCount;
    logic sawDone;
    res_t r;
    logic [N-1:0] ra, rb;
    logic rbin;

    vecs[0] = '{8'hAA, 8'hCC, 1'b0, 8'hDE, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    compare("reset.busy", 32'(busy), 32'd0);
    compare("reset.done", 32'(done), 32'd0);
    compare("reset.diff", 32'(diff), 32'd0);
    compare("reset.bout", 32'(bout), 32'd0);
    compare("reset.ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      checkOutput($sformatf("vec%0d", i), vecs[i].expDiff, vecs[i].expBout, vecs[i].expOvf, lat);
    end

    // Start held high: new operands presented in the DONE cycle launch with no IDLE gap.
    aIn = 8'hAA; bIn = 8'hCC; binIn = 1'b0; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < MaxWait);
    compare("b2b.first.latency", 32'(lat), 32'(N + 1));
    compare("b2b.first.diff", 32'(diff), 32'hDE);
    compare("b2b.first.bout", 32'(bout), 32'd1);
    aIn = 8'h55; bIn = 8'h55;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) compare("b2b.noIdle.busy", 32'(busy), 32'd1);
    end while (!done && lat < MaxWait);
    start = 1'b0;
    compare("b2b.spacing", 32'(lat), 32'(N + 1));
    compare("b2b.second.diff", 32'(diff), 32'h00);
    compare("b2b.second.bout", 32'(bout), 32'd0);
    @(negedge clk);
    compare("b2b.idle.busy", 32'(busy), 32'd0);

    // Start pulses during RUN with changed operands must be ignored.
    aIn = 8'h80; bIn = 8'h01; binIn = 1'b0; start = 1'b1;
    doneCount = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      aIn   = 8'hFF;
      bIn   = 8'h00;
      binIn = 1'b1;
      start = (k == 3 || k == 5);
      if (done) begin
        doneCount++;
        compare("ignore.latency", 32'(k), 32'(N + 1));
        compare("ignore.diff", 32'(diff), 32'h7F);
        compare("ignore.bout", 32'(bout), 32'd0);
        compare("ignore.ovf",  32'(ovf),  32'd1);
      end
    end
    start = 1'b0;
    compare("ignore.doneCount", 32'(doneCount), 32'd1);

    // Asynchronous reset in the middle of RUN discards the partial result.
    aIn = 8'h12; bIn = 8'h34; binIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("midReset.busy", 32'(busy), 32'd0);
    compare("midReset.done", 32'(done), 32'd0);
    compare("midReset.diff", 32'(diff), 32'd0);
    compare("midReset.bout", 32'(bout), 32'd0);
    compare("midReset.ovf",  32'(ovf),  32'd0);
    sawDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    compare("midReset.noDone", 32'(sawDone), 32'd0);
    rst_n = 1'b1;
    applyStimulus(8'h34, 8'h12, 1'b1, lat);
    checkOutput("afterReset", 8'h21, 1'b0, 1'b0, lat);

    // Start already high when reset releases: the first edge accepts.
    rst_n = 1'b0;
    aIn = 8'h01; bIn = 8'h02; binIn = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h01, 8'h02, 1'b0, lat);
    checkOutput("releaseStart", 8'hFF, 1'b1, 1'b0, lat);

    for (int i = 0; i < 1004; i++) begin
      case (i)
        0:       begin ra = '0; rb = '0; rbin = 1'b0; end
        1:       begin ra = '1; rb = '1; rbin = 1'b1; end
        2:       begin ra = '0; rb = '1; rbin = 1'b1; end
        3:       begin ra = '1; rb = '0; rbin = 1'b0; end
        default: begin
          ra   = N'($urandom);
          rb   = N'($urandom);
          rbin = 1'($urandom_range(0, 1));
        end
      endcase
      r = refSub(ra, rb, rbin);
      applyStimulus(ra, rb, rbin, lat);
      checkOutput($sformatf("sweep%0d", i), r.diff, r.bout, r.ovf, lat);
    end

    compare("busyDoneOverlap", 32'(overlapCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial subtractor computing `diff = a - b - bin` one bit per clock, LSB first, with a start/busy/done handshake. It is the sequential, inverse-operation counterpart of the team's combinational ripple-carry adder. It trades N cycles of latency for a single full-subtractor cell. It sits beside the adder in the arithmetic test suite and is checked against the same operand vectors.

## Interface
Parameters:
- `N`, default 8: operand width in bits; N ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a subtraction. Sampled only in IDLE or DONE.
- `a`, input, N: minuend. Captured on the edge that accepts `start`.
- `b`, input, N: subtrahend. Captured with `a`.
- `bin`, input, 1: borrow-in. Captured with `a`.
- `busy`, output, 1: high while bits are being processed (RUN state).
- `done`, output, 1: one-cycle pulse; results are valid in this cycle.
- `diff`, output, N: result bits. Held from `done` until the next accepted `start`.
- `bout`, output, 1: borrow-out. Equals 1 exactly when `a < b + bin` (unsigned).
- `ovf`, output, 1: two's-complement overflow. Equals borrow into the MSB XOR `bout`.

## Operation
- Reset (asynchronous, `rst_n`=0): state=IDLE; `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0; bit counter and internal borrow cleared. Reset has immediate effect, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1. Capture `a`, `b` into shift registers and `bin` into the borrow flop; clear the counter.
  - RUN: each cycle processes bit 0 of the shift registers.
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - Shift d into the MSB of the `diff` register; shift the operands right; increment the counter.
    - `start` is ignored in RUN.
  - RUN → DONE after the bit with counter = N-1. On that edge, register `bout` = br' and `ovf` = br (borrow into the MSB) ^ br'.
  - DONE: `done`=1 for exactly this cycle.
    - DONE → RUN if `start`=1 (back-to-back; new operands captured).
    - Otherwise DONE → IDLE.
- `diff`, `bout`, `ovf` change only on the final RUN edge or on reset. They hold through IDLE.
- Arithmetic is modulo 2^N. No operand value is illegal.

## Timing
- Start edge E0 (IDLE or DONE with `start`=1) → `busy`=1 from E0 until EN.
- Bit i is processed on edge E(i+1). State = DONE after EN; `done` is high in the cycle following EN, i.e. N+1 cycles after the start edge.
- Throughput: one result per N+1 cycles with back-to-back starts.
- `busy` and `done` are never high together.
- `start` held high continuously causes back-to-back operations, each re-capturing the current `a`/`b`/`bin`.
- Reset deasserted while `start`=1: the first edge after release accepts the request.

## Structure
- Package `serial_sub_pkg`: state enumeration (IDLE=2'd0, RUN=2'd1, DONE=2'd2). Counter width is $clog2(N).
- Sub-module `full_sub`: 1-bit combinational full subtractor with inputs a, b, br and outputs d, bo. Instantiated once and reused each cycle.
- Top level holds the FSM, operand shift registers, result shift register, borrow flop and counter.

## Test plan
- N=8, `a`=0xAA, `b`=0xCC, `bin`=0 → after N+1 cycles `done`=1, `diff`=0xDE, `bout`=1, `ovf`=0.
- `a`=0x80, `b`=0x01, `bin`=0 → `diff`=0x7F, `bout`=0, `ovf`=1. Then `a`=0x00, `b`=0x00, `bin`=1 → `diff`=0xFF, `bout`=1, `ovf`=0.
- Start held high with a new operand (`a`=0x55, `b`=0x55) applied in the DONE cycle → second operation starts with no IDLE cycle; `diff`=0x00, `bout`=0; `done` pulses 9 cycles apart.
- `start` pulsed at cycles 3 and 5 of RUN with different operands → ignored; the result matches the original operands and exactly one `done` pulse occurs.
- `rst_n` driven low at cycle 4 of RUN → all outputs are 0 immediately; no `done`. A fresh `start` after release gives the correct result for the new operands.
- Randomized sweep of 1000 vectors plus all-zero and all-ones corners, checked against a `a - b - bin` reference model → every `diff`/`bout`/`ovf` matches; `done` latency is always N+1.
